rst_heartbeat_ctrl: RTL and testbench

- Parametrised board-level reset sequencer and status-LED heartbeat generator, instantiated in the FPGA top next to the clock generator.
- Synchronises and debounces the external reset button and accepts a software reset request.
- Drives NumRstOut active-low reset outputs, released one at a time in order, after a programmable power-on hold.
- Generates a heartbeat LED with selectable mode and a halted override.

---
 rtl/rst_heartbeat_pkg.sv | 26 ++
 rtl/rst_heartbeat_ctrl_sync_debounce.sv | 45 ++++
 rtl/rst_heartbeat_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_rst_heartbeat_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_heartbeat_pkg.sv
// Shared types for the board reset sequencer: FSM states, heartbeat modes
// and the helper that resolves the effective heartbeat mode.
package rst_heartbeat_pkg;

    typedef enum logic [1:0] {
        ST_POR     = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        HB_OFF   = 2'd0,
        HB_SLOW  = 2'd1,
        HB_SOLID = 2'd2,
        HB_FAST  = 2'd3
    } hb_mode_e;

    localparam logic BtnReleased = 1'b1;

    // A halted core forces the fast blink so it is visible on the board.
    function automatic hb_mode_e eff_mode(input logic halted, input logic [1:0] mode);
        return halted ? HB_FAST : hb_mode_e'(mode);
    endfunction

endpackage

// File: rtl/rst_heartbeat_ctrl_sync_debounce.sv
// Two-flop synchroniser on the raw reset button followed by a debounce
// counter; o_level is the accepted (debounced) active-low button level.
module sync_debounce
    import rst_heartbeat_pkg::*;
#(
    parameter int DebounceCycles = 16,
    parameter int CntWidth       = 32
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin_n,
    output logic o_level
);

    localparam logic [CntWidth-1:0] DbTerm = CntWidth'(DebounceCycles - 1);

    logic                r_sync1;
    logic                r_sync2;
    logic                r_level;
    logic [CntWidth-1:0] r_cnt;

    // Synchroniser and debounce: a change is accepted after DebounceCycles differing samples.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= BtnReleased;
            r_sync2 <= BtnReleased;
            r_level <= BtnReleased;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_pin_n;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == DbTerm) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CntWidth'(1);
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/rst_heartbeat_ctrl.sv
// Board reset sequencer: POR hold, staggered in-order release of the reset
// outputs, button/software re-reset via HOLD, and the status-LED heartbeat.
module rst_heartbeat_ctrl
    import rst_heartbeat_pkg::*;
#(
    parameter int NumRstOut      = 3,
    parameter int PorCycles      = 200,
    parameter int HoldCycles     = 200,
    parameter int StaggerCycles  = 8,
    parameter int DebounceCycles = 16,
    parameter int HbHalfPeriod   = 5000000,
    parameter int CntWidth       = 32
) (
    input  logic                 clk_sys_i,
    input  logic                 rst_sys_ni,
    input  logic                 ext_rst_ni,
    input  logic                 sw_rst_req_i,
    input  logic                 halted_i,
    input  logic [1:0]           hb_mode_i,
    output logic [NumRstOut-1:0] rst_no,
    output logic                 rst_done_o,
    output logic                 hb_led_o
);

    localparam int IdxW = (NumRstOut > 1) ? $clog2(NumRstOut) : 1;
    localparam logic [CntWidth-1:0]  PorTerm  = CntWidth'(PorCycles - 1);
    localparam logic [CntWidth-1:0]  HoldTerm = CntWidth'(HoldCycles - 1);
    localparam logic [CntWidth-1:0]  StgTerm  = CntWidth'(StaggerCycles - 1);
    localparam logic [CntWidth-1:0]  SlowTerm = CntWidth'(HbHalfPeriod - 1);
    localparam logic [CntWidth-1:0]  FastTerm = CntWidth'(HbHalfPeriod / 8 - 1);
    localparam logic [IdxW-1:0]      LastIdx  = IdxW'(NumRstOut - 1);
    localparam logic [NumRstOut-1:0] Bit0     = NumRstOut'(1);

    logic                 w_btn_n;
    logic                 w_abort;
    state_e               r_state, w_state_nxt;
    logic [CntWidth-1:0]  r_cnt, w_cnt_nxt;
    logic [IdxW-1:0]      r_idx, w_idx_nxt;
    logic [NumRstOut-1:0] r_rst_n, w_rst_n_nxt;
    logic                 r_done, w_done_nxt;
    hb_mode_e             r_hb_mode, w_eff_mode;
    logic [CntWidth-1:0]  r_hb_cnt, w_hb_cnt_nxt, w_hb_term;
    logic                 r_hb_led, w_hb_led_nxt;

    sync_debounce #(
        .DebounceCycles(DebounceCycles),
        .CntWidth      (CntWidth)
    ) u_sync_debounce (
        .i_clk  (clk_sys_i),
        .i_rst_n(rst_sys_ni),
        .i_pin_n(ext_rst_ni),
        .o_level(w_btn_n)
    );

    assign w_abort = !w_btn_n || sw_rst_req_i;

    // Sequencer next state: one shared counter serves POR, HOLD and the stagger gap.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_rst_n_nxt = r_rst_n;
        w_done_nxt  = r_done;
        case (r_state)
            ST_POR: begin
                if (r_cnt == PorTerm) begin
                    w_state_nxt = ST_RELEASE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CntWidth'(1);
                end
            end
            ST_HOLD: begin
                w_rst_n_nxt = '0;
                w_done_nxt  = 1'b0;
                w_idx_nxt   = '0;
                if (w_abort) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == HoldTerm) begin
                    w_state_nxt = ST_RELEASE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CntWidth'(1);
                end
            end
            ST_RELEASE: begin
                // A request on the final release edge still wins, so done never pulses.
                if (w_abort) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_rst_n_nxt = '0;
                    w_done_nxt  = 1'b0;
                end else if (r_cnt == StgTerm) begin
                    w_cnt_nxt   = '0;
                    w_rst_n_nxt = r_rst_n | (Bit0 << r_idx);
                    if (r_idx == LastIdx) begin
                        w_state_nxt = ST_RUN;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + IdxW'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CntWidth'(1);
                end
            end
            ST_RUN: begin
                w_cnt_nxt = '0;
                if (w_abort) begin
                    w_state_nxt = ST_HOLD;
                    w_idx_nxt   = '0;
                    w_rst_n_nxt = '0;
                    w_done_nxt  = 1'b0;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_POR;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
                w_rst_n_nxt = '0;
                w_done_nxt  = 1'b0;
            end
        endcase
    end

    assign w_eff_mode = eff_mode(halted_i, hb_mode_i);
    assign w_hb_term  = (w_eff_mode == HB_FAST) ? FastTerm : SlowTerm;

    // Heartbeat next state: held at LED on outside RUN, including the exit cycle.
    always_comb begin
        w_hb_cnt_nxt = r_hb_cnt;
        w_hb_led_nxt = r_hb_led;
        if ((r_state != ST_RUN) || (w_state_nxt != ST_RUN)) begin
            w_hb_cnt_nxt = '0;
            w_hb_led_nxt = 1'b1;
        end else if (w_eff_mode != r_hb_mode) begin
            w_hb_cnt_nxt = '0;
            w_hb_led_nxt = (w_eff_mode != HB_OFF);
        end else begin
            case (w_eff_mode)
                HB_OFF: begin
                    w_hb_cnt_nxt = '0;
                    w_hb_led_nxt = 1'b0;
                end
                HB_SOLID: begin
                    w_hb_cnt_nxt = '0;
                    w_hb_led_nxt = 1'b1;
                end
                HB_SLOW, HB_FAST: begin
                    if (r_hb_cnt == w_hb_term) begin
                        w_hb_cnt_nxt = '0;
                        w_hb_led_nxt = !r_hb_led;
                    end else begin
                        w_hb_cnt_nxt = r_hb_cnt + CntWidth'(1);
                    end
                end
                default: begin
                    w_hb_cnt_nxt = '0;
                    w_hb_led_nxt = 1'b1;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk_sys_i) begin
        if (!rst_sys_ni) begin
            r_state   <= ST_POR;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_rst_n   <= '0;
            r_done    <= 1'b0;
            r_hb_mode <= HB_OFF;
            r_hb_cnt  <= '0;
            r_hb_led  <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_rst_n   <= w_rst_n_nxt;
            r_done    <= w_done_nxt;
            r_hb_mode <= w_eff_mode;
            r_hb_cnt  <= w_hb_cnt_nxt;
            r_hb_led  <= w_hb_led_nxt;
        end
    end

    assign rst_no     = r_rst_n;
    assign rst_done_o = r_done;
    assign hb_led_o   = r_hb_led;

endmodule

// File: tb/tb_rst_heartbeat_ctrl.sv
// Self-checking bench for rst_heartbeat_ctrl: a timeline model predicts the
// outputs every cycle, and directed literal checks pin key cycles.
module tb_rst_heartbeat_ctrl;

    localparam int N    = 3;
    localparam int POR  = 10;
    localparam int HOLD = 6;
    localparam int STG  = 4;
    localparam int DB   = 4;
    localparam int HB   = 16;

    logic         clk = 1'b0;
    logic         rst_sys_n = 1'b0;
    logic         ext_rst_n = 1'b1;
    logic         sw_req = 1'b0;
    logic         halted = 1'b0;
    logic [1:0]   hb_mode = 2'd1;
    logic [N-1:0] rst_n;
    logic         done;
    logic         led;

    always #5 clk = ~clk;

    rst_heartbeat_ctrl #(
        .NumRstOut     (N),
        .PorCycles     (POR),
        .HoldCycles    (HOLD),
        .StaggerCycles (STG),
        .DebounceCycles(DB),
        .HbHalfPeriod  (HB),
        .CntWidth      (32)
    ) dut (
        .clk_sys_i   (clk),
        .rst_sys_ni  (rst_sys_n),
        .ext_rst_ni  (ext_rst_n),
        .sw_rst_req_i(sw_req),
        .halted_i    (halted),
        .hb_mode_i   (hb_mode),
        .rst_no      (rst_n),
        .rst_done_o  (done),
        .hb_led_o    (led)
    );

    int checks = 0;
    int failures = 0;

    // Model: cycle 0 ends at the first edge that samples reset released.
    // Release counts are measured from an anchor cycle where a hold/POR count is 0.
    int       cyc = 0;
    bit       model_ok = 1'b0;
    int       anc, len;
    bit       por_epoch;
    bit       deb_m;
    bit       pin_hist [0:1023];
    int       seg_start, seg_mode, eff_prev;
    bit       seg_entry;
    logic [N-1:0] exp_rst;
    logic     exp_done, exp_led;
    int       m_c, m_n_next, m_eff;
    bit       m_abort, m_run_now, m_run_next, m_all_diff;

    function automatic int rel_count(input int t);
        int k;
        if (t < anc + len) return 0;
        k = (t - anc - len) / STG;
        return (k > N) ? N : k;
    endfunction

    function automatic int sync_at(input int t);
        if (t < 2) return 1;
        return int'(pin_hist[t-2]);
    endfunction

    function automatic bit led_at(input int t);
        if (t == seg_start) return seg_entry ? 1'b1 : (seg_mode != 0);
        case (seg_mode)
            0:       return 1'b0;
            2:       return 1'b1;
            1:       return ((t - seg_start) / HB) % 2 == 0;
            default: return ((t - seg_start) / (HB / 8)) % 2 == 0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Model update on every active edge, from the inputs only.
    initial forever begin
        @(posedge clk);
        if (!rst_sys_n) begin
            cyc = 0; anc = 0; len = POR; por_epoch = 1'b1; deb_m = 1'b1;
            eff_prev = 0; seg_start = 0; seg_mode = 0; seg_entry = 1'b1;
            exp_rst = '0; exp_done = 1'b0; exp_led = 1'b1; model_ok = 1'b1;
        end else begin
            m_c = cyc;
            if (m_c < 1024) pin_hist[m_c] = ext_rst_n;
            m_run_now = (rel_count(m_c) == N);
            m_abort = !(por_epoch && m_c < anc + len) && (!deb_m || sw_req);
            if (m_abort) begin
                anc = m_c + 1; len = HOLD; por_epoch = 1'b0;
            end
            m_n_next   = rel_count(m_c + 1);
            m_run_next = (m_n_next == N);
            m_eff = halted ? 3 : int'(hb_mode);
            if (m_run_next && !m_run_now) begin
                seg_start = m_c + 1; seg_mode = m_eff; seg_entry = 1'b1;
            end else if (m_run_next && m_eff != eff_prev) begin
                seg_start = m_c + 1; seg_mode = m_eff; seg_entry = 1'b0;
            end
            eff_prev = m_eff;
            exp_led  = m_run_next ? led_at(m_c + 1) : 1'b1;
            exp_rst  = N'((1 << m_n_next) - 1);
            exp_done = m_run_next;
            m_all_diff = 1'b1;
            for (int k = 0; k < DB; k++)
                if (sync_at(m_c - k) == int'(deb_m)) m_all_diff = 1'b0;
            if (m_all_diff) deb_m = !deb_m;
            cyc = m_c + 1;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (model_ok) begin
            chk("rst_no", 32'(rst_n), 32'(exp_rst));
            chk("rst_done", 32'(done), 32'(exp_done));
            chk("hb_led", 32'(led), 32'(exp_led));
        end
    end

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        chk("wait_bound", 32'(cyc >= n), 32'h1);
    endtask

    task automatic pin_rst(input int at, input logic [N-1:0] v, input logic d);
        wait_cyc(at);
        chk("lit_rst_no", 32'(rst_n), 32'(v));
        chk("lit_rst_done", 32'(done), 32'(d));
        chk("lit_model_rst", 32'(exp_rst), 32'(v));
    endtask

    task automatic pin_led(input int at, input logic v);
        wait_cyc(at);
        chk("lit_hb_led", 32'(led), 32'(v));
        chk("lit_model_led", 32'(exp_led), 32'(v));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_rst_no", 32'(rst_n), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_led", 32'(led), 32'h1);
        rst_sys_n = 1'b1;

        // Power-on release and slow blink
        pin_rst(13, 3'b000, 1'b0);
        pin_rst(14, 3'b001, 1'b0);
        pin_rst(17, 3'b001, 1'b0);
        pin_rst(18, 3'b011, 1'b0);
        pin_rst(21, 3'b011, 1'b0);
        pin_rst(22, 3'b111, 1'b1);
        pin_led(22, 1'b1);
        pin_led(37, 1'b1);
        pin_led(38, 1'b0);
        pin_led(54, 1'b1);

        // Halted forces fast blink; then off, solid, back to slow
        wait_cyc(60); halted = 1'b1;
        pin_led(61, 1'b1);
        pin_led(62, 1'b1);
        pin_led(63, 1'b0);
        pin_led(65, 1'b1);
        wait_cyc(70); halted = 1'b0; hb_mode = 2'd0;
        pin_led(71, 1'b0);
        pin_led(72, 1'b0);
        wait_cyc(75); hb_mode = 2'd2;
        pin_led(76, 1'b1);
        wait_cyc(80); hb_mode = 2'd1;

        // Button glitch then a real press
        wait_cyc(90); ext_rst_n = 1'b0;
        wait_cyc(93); ext_rst_n = 1'b1;
        pin_rst(100, 3'b111, 1'b1);
        wait_cyc(110); ext_rst_n = 1'b0;
        pin_rst(116, 3'b111, 1'b1);
        pin_rst(117, 3'b000, 1'b0);
        pin_led(117, 1'b1);
        wait_cyc(130); ext_rst_n = 1'b1;
        pin_rst(145, 3'b000, 1'b0);
        pin_rst(146, 3'b001, 1'b0);
        pin_rst(150, 3'b011, 1'b0);
        pin_rst(153, 3'b011, 1'b0);
        pin_rst(154, 3'b111, 1'b1);

        // Software request in RUN
        wait_cyc(170); sw_req = 1'b1;
        wait_cyc(171); sw_req = 1'b0;
        pin_rst(171, 3'b000, 1'b0);
        pin_rst(180, 3'b000, 1'b0);
        pin_rst(181, 3'b001, 1'b0);
        pin_rst(185, 3'b011, 1'b0);
        pin_rst(189, 3'b111, 1'b1);

        // Interrupted release, request on the final release, restart in HOLD
        wait_cyc(200); sw_req = 1'b1;
        wait_cyc(201); sw_req = 1'b0;
        pin_rst(211, 3'b001, 1'b0);
        wait_cyc(212); sw_req = 1'b1;
        wait_cyc(213); sw_req = 1'b0;
        pin_rst(213, 3'b000, 1'b0);
        pin_rst(223, 3'b001, 1'b0);
        pin_rst(227, 3'b011, 1'b0);
        pin_rst(230, 3'b011, 1'b0);
        sw_req = 1'b1;
        wait_cyc(231); sw_req = 1'b0;
        pin_rst(231, 3'b000, 1'b0);
        wait_cyc(235); sw_req = 1'b1;
        wait_cyc(236); sw_req = 1'b0;
        pin_rst(245, 3'b000, 1'b0);
        pin_rst(246, 3'b001, 1'b0);
        pin_rst(253, 3'b011, 1'b0);
        pin_rst(254, 3'b111, 1'b1);

        // Fast mode selected directly, then slow again
        wait_cyc(260); hb_mode = 2'd3;
        pin_led(261, 1'b1);
        pin_led(263, 0);
        wait_cyc(270); hb_mode = 2'd1;

        // Reset mid-blink restarts the power-on sequence
        wait_cyc(300); rst_sys_n = 1'b0;
        @(negedge clk);
        chk("midreset_rst_no", 32'(rst_n), 32'h0);
        chk("midreset_done", 32'(done), 32'h0);
        chk("midreset_led", 32'(led), 32'h1);
        @(negedge clk);
        rst_sys_n = 1'b1;
        pin_rst(13, 3'b000, 1'b0);
        pin_rst(14, 3'b001, 1'b0);
        pin_rst(22, 3'b111, 1'b1);
        pin_led(30, 1'b1);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
